// File: rtl/fsm_step_sequencer.sv
//------------------------------------------------------------------------------
// fsm_step_sequencer
//
// Drives a 2-bit enable-gated counter one step at a time. A start request
// (accepted only while idle) latches a step count. For each step the
// sequencer issues a one-cycle E pulse. It then waits until S changes before
// it issues the next pulse. If S stays put for TIMEOUT cycles, the sequence
// stops and the sticky err flag is raised.
//
// Parameters
//   CNT_W    width of the step count and the remaining counter
//   GAP      idle cycles inserted after each confirmed step (0 = back-to-back)
//   TIMEOUT  cycles allowed in CHECK without an S change (>= 1)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous reset, active low
//   start      in   start request, accepted only in IDLE
//   steps      in   number of E pulses, sampled with the accepted start
//   abort      in   cancels a running sequence
//   S          in   current state of the sequenced counter
//   E          out  single-cycle enable pulses to the counter
//   busy       out  high while in PULSE / CHECK / GAP
//   done       out  one-cycle pulse when a sequence completes
//   err        out  sticky timeout flag, cleared by the next accepted start
//   remaining  out  steps not yet confirmed
//
// All outputs come from registers or from state decode only. No input has a
// combinational path to an output.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module fsm_step_sequencer #(
    parameter int CNT_W   = 8,
    parameter int GAP     = 0,
    parameter int TIMEOUT = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] steps,
    input  logic             abort,
    input  logic [1:0]       S,
    output logic             E,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] remaining
);

    // Counter widths are kept at a minimum of one bit, so that the degenerate
    // parameter values (GAP of 0 or 1, TIMEOUT of 1) still elaborate.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] G_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE,
        ST_CHECK,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] remaining_q;
    logic             err_q;
    logic [1:0]       s_prev_q;
    logic [TW-1:0]    tcnt_q;
    logic [GW-1:0]    gcnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            err_q       <= 1'b0;
            s_prev_q    <= 2'b00;
            tcnt_q      <= '0;
            gcnt_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        remaining_q <= steps;
                        err_q       <= 1'b0;
                        state_q     <= (steps != '0) ? ST_PULSE : ST_DONE;
                    end
                end

                ST_PULSE: begin
                    // E is already high in this cycle. An abort here does not
                    // withdraw the pulse. It only stops anything that follows.
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else begin
                        s_prev_q <= S;
                        tcnt_q   <= '0;
                        state_q  <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else if (S != s_prev_q) begin
                        // Any change of S counts as a confirmed step,
                        // including the wrap from 11 to 00.
                        if (remaining_q != '0)
                            remaining_q <= remaining_q - CNT_W'(1);
                        if (remaining_q <= CNT_W'(1)) begin
                            state_q <= ST_DONE;
                        end else if (GAP > 0) begin
                            gcnt_q  <= '0;
                            state_q <= ST_GAP;
                        end else begin
                            state_q <= ST_PULSE;
                        end
                    end else if (tcnt_q == T_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= ST_ERR;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end

                ST_GAP: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else if (gcnt_q == G_LAST) begin
                        state_q <= ST_PULSE;
                    end else begin
                        gcnt_q <= gcnt_q + GW'(1);
                    end
                end

                ST_DONE: state_q <= ST_IDLE;

                // err_q was set on entry. remaining_q keeps the count of
                // unconfirmed steps for the host to read.
                ST_ERR:  state_q <= ST_IDLE;

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign E         = (state_q == ST_PULSE);
    assign busy      = (state_q == ST_PULSE) || (state_q == ST_CHECK) || (state_q == ST_GAP);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_fsm_step_sequencer.sv
`timescale 1ns/1ps

module tb_fsm_step_sequencer;

    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] steps;
    logic             abort;
    logic [1:0]       S;
    logic             E;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] remaining;

    // When plant_en is low, the counter ignores E (E disconnected).
    logic plant_en;

    int n_checks;
    int n_fail;

    fsm_step_sequencer #(
        .CNT_W   (CNT_W),
        .GAP     (0),
        .TIMEOUT (7)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .steps     (steps),
        .abort     (abort),
        .S         (S),
        .E         (E),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .remaining (remaining)
    );

    // Plant: 2-bit enable-gated state counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            S <= 2'b00;
        else if (E && plant_en)
            S <= S + 2'b01;
    end

    initial clk = 1'b0;
    always #1 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle and land at mid-cycle (falling edge).
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Start a sequence of n steps with a healthy counter and no gap. Check E,
    // done, busy and remaining in every cycle 1..2n+1. If inject_c > 0, a
    // second start is asserted in that cycle. That start must be ignored.
    task automatic run_seq(input string tag, input int n, input int inject_c);
        int pulses;
        pulses = 0;
        start  = 1'b1;
        steps  = CNT_W'(n);
        for (int c = 1; c <= 2 * n + 1; c++) begin
            tick();
            start = 1'b0;
            if (E) pulses++;
            check({tag, "_E"},    int'(E),    ((c % 2 == 1) && (c <= 2 * n - 1)) ? 1 : 0);
            check({tag, "_done"}, int'(done), (c == 2 * n + 1) ? 1 : 0);
            check({tag, "_busy"}, int'(busy), (c <= 2 * n) ? 1 : 0);
            check({tag, "_rem"},  int'(remaining), n - (c - 1) / 2);
            if (c == inject_c) begin
                start = 1'b1;
                steps = CNT_W'(2);
            end
        end
        tick();
        check({tag, "_pulses"},    pulses, n);
        check({tag, "_idle_done"}, int'(done), 0);
        check({tag, "_idle_busy"}, int'(busy), 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        start    = 1'b0;
        steps    = '0;
        abort    = 1'b0;
        plant_en = 1'b1;

        tick();
        tick();
        check("rst_E",    int'(E), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err",  int'(err), 0);
        check("rst_rem",  int'(remaining), 0);
        reset = 1'b1;
        tick();

        // Test 1: asynchronous reset in the middle of a sequence.
        start = 1'b1;
        steps = CNT_W'(4);
        tick();
        start = 1'b0;
        tick();
        tick();
        check("t1_busy_pre", int'(busy), 1);
        check("t1_E_pre",    int'(E), 1);
        reset = 1'b0;
        #0.1;
        check("t1_E",    int'(E), 0);
        check("t1_busy", int'(busy), 0);
        check("t1_done", int'(done), 0);
        check("t1_err",  int'(err), 0);
        check("t1_rem",  int'(remaining), 0);
        tick();
        reset = 1'b1;
        tick();
        check("t1_after_busy", int'(busy), 0);
        check("t1_after_E",    int'(E), 0);
        check("t1_after_S",    int'(S), 0);
        $display("txn reset_mid_sequence S=%0d", S);

        // Test 2: three steps from S=00.
        run_seq("t2", 3, 0);
        check("t2_S", int'(S), 3);
        $display("txn steps=3 S=%0d remaining=%0d", S, remaining);

        // Test 3: five steps from S=00. S wraps from 11 to 00 and ends at 01.
        pulse_reset();
        run_seq("t3", 5, 0);
        check("t3_S", int'(S), 1);
        $display("txn steps=5 S=%0d remaining=%0d", S, remaining);

        // Test 4: the counter ignores E, so the sequence stops with a timeout.
        plant_en = 1'b0;
        start    = 1'b1;
        steps    = CNT_W'(2);
        for (int c = 1; c <= 9; c++) begin
            tick();
            start = 1'b0;
            check("t4_E",    int'(E),    (c == 1) ? 1 : 0);
            check("t4_busy", int'(busy), (c <= 8) ? 1 : 0);
            check("t4_err",  int'(err),  (c == 9) ? 1 : 0);
            check("t4_done", int'(done), 0);
        end
        tick();
        check("t4_err_sticky", int'(err), 1);
        check("t4_rem",        int'(remaining), 2);
        check("t4_busy_idle",  int'(busy), 0);
        plant_en = 1'b1;
        start    = 1'b1;
        steps    = CNT_W'(1);
        tick();
        start = 1'b0;
        check("t4_err_clr", int'(err), 0);
        check("t4_E_new",   int'(E), 1);
        tick();
        tick();
        check("t4_done_new", int'(done), 1);
        $display("txn timeout err=%0d remaining=%0d", err, remaining);

        // Test 5: abort in cycle 3, while the second pulse is high.
        pulse_reset();
        start = 1'b1;
        steps = CNT_W'(4);
        tick();
        start = 1'b0;
        tick();
        tick();
        check("t5_E_c3", int'(E), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_busy_c4", int'(busy), 0);
        check("t5_E_c4",    int'(E), 0);
        check("t5_rem",     int'(remaining), 3);
        for (int c = 5; c <= 8; c++) begin
            tick();
            check("t5_done", int'(done), 0);
            check("t5_E",    int'(E), 0);
        end
        check("t5_S",   int'(S), 2);
        check("t5_err", int'(err), 0);
        $display("txn abort S=%0d remaining=%0d", S, remaining);

        // Test 6: zero steps, then a start issued while busy.
        run_seq("t6z", 0, 0);
        $display("txn steps=0 done_seen S=%0d", S);
        pulse_reset();
        run_seq("t6b", 9, 2);
        check("t6b_S", int'(S), 1);
        $display("txn steps=9 with ignored start S=%0d remaining=%0d", S, remaining);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
